// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU front-end: ALU opcodes, token kinds
// and the sequencer state encoding.
package stack_alu_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned TOK_W = 2;

    // ALU opcodes driven on alu_opcode
    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_PUSH = 3'b110;
    localparam logic [OP_W-1:0] OP_POP  = 3'b111;

    // Token kinds on tok_kind
    localparam logic [TOK_W-1:0] TOK_OPND = 2'b00;
    localparam logic [TOK_W-1:0] TOK_ADD  = 2'b01;
    localparam logic [TOK_W-1:0] TOK_MUL  = 2'b10;
    localparam logic [TOK_W-1:0] TOK_END  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/stack_alu_sequencer.sv
// RPN token sequencer in front of a stack-based ALU.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   tok_valid/ready/kind/data - postfix token stream in
//   alu_opcode, alu_in        - registered command to the ALU
//   alu_out, alu_overflow     - ALU result and overflow (registered in the ALU)
//   res_valid/ready/data      - expression result handshake
//   res_overflow, res_error   - sticky overflow / malformed-expression flags
//   busy                      - high while flushing or holding a result
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [TOK_W-1:0] tok_kind,
    input  logic [N-1:0]     tok_data,
    output logic [OP_W-1:0]  alu_opcode,
    output logic [N-1:0]     alu_in,
    input  logic [N-1:0]     alu_out,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_overflow,
    output logic             res_error,
    output logic             busy
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [OP_W-1:0] alu_opcode_q, alu_opcode_d;
    logic [N-1:0]    alu_in_q, alu_in_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;
    logic            tok_ready_q, tok_ready_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    // arith_pend: arith opcode on the bus; ovf_fold: its overflow is visible now
    logic            arith_pend_q, arith_pend_d;
    logic            ovf_fold_q, ovf_fold_d;
    // pop1: first flush pop on the bus; cap: alu_out holds the popped result
    logic            pop1_q, pop1_d;
    logic            cap_q, cap_d;
    logic            cap_done_q, cap_done_d;
    logic            tok_accept;

    assign tok_accept = tok_valid & tok_ready_q;

    // Next-state, ALU command and result bookkeeping
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        alu_opcode_d = OP_NOP;
        alu_in_d     = alu_in_q;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        err_d        = err_q;
        ovf_d        = ovf_q | (ovf_fold_q & alu_overflow);
        arith_pend_d = 1'b0;
        ovf_fold_d   = arith_pend_q;
        pop1_d       = 1'b0;
        cap_d        = pop1_q;
        cap_done_d   = cap_done_q;

        case (state_q)
            ST_RUN: begin
                if (tok_accept) begin
                    case (tok_kind)
                        TOK_OPND: begin
                            if (depth_q < DW'(DEPTH)) begin
                                alu_opcode_d = OP_PUSH;
                                alu_in_d     = tok_data;
                                depth_d      = depth_q + DW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        TOK_ADD, TOK_MUL: begin
                            if (depth_q >= DW'(2)) begin
                                alu_opcode_d = (tok_kind == TOK_ADD) ? OP_ADD : OP_MUL;
                                depth_d      = depth_q - DW'(1);
                                arith_pend_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if (depth_q != DW'(1)) begin
                                err_d = 1'b1;
                            end
                            state_d = ST_FLUSH;
                            if (depth_q == '0) begin
                                res_data_d = '0;
                                cap_done_d = 1'b1;
                            end else begin
                                // first pop issued here so pops fill cycles k+1..k+D
                                alu_opcode_d = OP_POP;
                                depth_d      = depth_q - DW'(1);
                                pop1_d       = 1'b1;
                                cap_done_d   = 1'b0;
                            end
                        end
                    endcase
                end
            end
            ST_FLUSH: begin
                if (depth_q != '0) begin
                    alu_opcode_d = OP_POP;
                    depth_d      = depth_q - DW'(1);
                end
                if (cap_q) begin
                    res_data_d = alu_out;
                    cap_done_d = 1'b1;
                end
                // leave once the last pop has executed and the result is captured
                if ((depth_q == '0) && (alu_opcode_q != OP_POP) && (cap_done_q || cap_q)) begin
                    state_d     = ST_RESULT;
                    res_valid_d = 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_RUN;
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        tok_ready_d = (state_d == ST_RUN);
        busy_d      = (state_d != ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            depth_q      <= '0;
            alu_opcode_q <= OP_NOP;
            alu_in_q     <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            tok_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            arith_pend_q <= 1'b0;
            ovf_fold_q   <= 1'b0;
            pop1_q       <= 1'b0;
            cap_q        <= 1'b0;
            cap_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            alu_opcode_q <= alu_opcode_d;
            alu_in_q     <= alu_in_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            tok_ready_q  <= tok_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            arith_pend_q <= arith_pend_d;
            ovf_fold_q   <= ovf_fold_d;
            pop1_q       <= pop1_d;
            cap_q        <= cap_d;
            cap_done_q   <= cap_done_d;
        end
    end

    assign tok_ready    = tok_ready_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_in       = alu_in_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_overflow = ovf_q;
    assign res_error    = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural stack ALU and a
// result scoreboard.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             tok_valid;
    logic             tok_ready;
    logic [TOK_W-1:0] tok_kind;
    logic [N-1:0]     tok_data;
    logic [OP_W-1:0]  alu_opcode;
    logic [N-1:0]     alu_in;
    logic [N-1:0]     alu_out;
    logic             alu_overflow;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_data;
    logic             res_overflow;
    logic             res_error;
    logic             busy;

    stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_kind    (tok_kind),
        .tok_data    (tok_data),
        .alu_opcode  (alu_opcode),
        .alu_in      (alu_in),
        .alu_out     (alu_out),
        .alu_overflow(alu_overflow),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_overflow(res_overflow),
        .res_error   (res_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack ALU: executes the opcode on the bus at each edge
    logic [N-1:0]   stk [0:DEPTH-1];
    logic [3:0]     sp;
    logic [N-1:0]   ta, tb2;
    logic [N:0]     sum9;
    logic [2*N-1:0] prod;

    assign ta   = (sp >= 4'd1) ? stk[3'(sp - 4'd1)] : '0;
    assign tb2  = (sp >= 4'd2) ? stk[3'(sp - 4'd2)] : '0;
    assign sum9 = {1'b0, ta} + {1'b0, tb2};
    assign prod = {8'h00, ta} * {8'h00, tb2};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp           <= '0;
            alu_out      <= '0;
            alu_overflow <= 1'b0;
        end else begin
            alu_overflow <= 1'b0;
            case (alu_opcode)
                OP_PUSH: if (sp < 4'd8) begin
                    stk[3'(sp)] <= alu_in;
                    sp          <= sp + 4'd1;
                end
                OP_ADD: if (sp >= 4'd2) begin
                    stk[3'(sp - 4'd2)] <= sum9[N-1:0];
                    sp                 <= sp - 4'd1;
                    alu_out            <= sum9[N-1:0];
                    alu_overflow       <= sum9[N];
                end
                OP_MUL: if (sp >= 4'd2) begin
                    stk[3'(sp - 4'd2)] <= prod[N-1:0];
                    sp                 <= sp - 4'd1;
                    alu_out            <= prod[N-1:0];
                    alu_overflow       <= |prod[2*N-1:N];
                end
                OP_POP: if (sp >= 4'd1) begin
                    alu_out <= ta;
                    sp      <= sp - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Log of non-nop opcodes seen on the ALU bus
    logic [OP_W-1:0] op_log [$];
    always @(posedge clk) begin
        if (!rst && alu_opcode != OP_NOP) op_log.push_back(alu_opcode);
    end

    typedef struct {
        logic [N-1:0] data;
        logic         ovf;
        logic         err;
        int           lat;
    } exp_t;
    exp_t exp_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tok(input logic [TOK_W-1:0] k, input logic [N-1:0] d);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_kind  = k;
        tok_data  = d;
        check("tok_ready_run", 32'(tok_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic expect_result(input logic [N-1:0] d, input logic o, input logic e, input int lat);
        exp_t x;
        x.data = d; x.ovf = o; x.err = e; x.lat = lat;
        exp_q.push_back(x);
    endtask

    // Waits for the result after an end token; hold = cycles res_ready stays low
    task automatic wait_result(input int hold);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        tok_valid = 1'b0;
        res_ready = (hold == 0);
        e   = exp_q.pop_front();
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (res_valid) got = 1'b1;
            else check("tok_ready_flush", 32'(tok_ready), 32'd0);
        end
        check("res_timeout", 32'(got), 32'd1);
        check("res_latency", 32'(n), 32'(e.lat));
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_overflow", 32'(res_overflow), 32'(e.ovf));
        check("res_error", 32'(res_error), 32'(e.err));
        check("busy_result", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(e.data));
            check("hold_flags", {30'd0, res_overflow, res_error}, {30'd0, e.ovf, e.err});
            check("hold_tok_ready", 32'(tok_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(res_valid), 32'd0);
        check("post_hs_tok_ready", 32'(tok_ready), 32'd1);
        check("post_hs_flags", {30'd0, res_overflow, res_error}, 32'd0);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    function automatic int count_op(input logic [OP_W-1:0] op);
        int c = 0;
        foreach (op_log[i]) if (op_log[i] == op) c++;
        return c;
    endfunction

    initial begin
        logic [OP_W-1:0] exp_ops [6];
        exp_ops = '{OP_PUSH, OP_PUSH, OP_ADD, OP_PUSH, OP_MUL, OP_POP};

        rst = 1'b1; tok_valid = 1'b0; tok_kind = TOK_OPND; tok_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_in", 32'(alu_in), 32'd0);
        check("rst_outputs", {26'd0, res_valid, res_data == '0 ? 1'b0 : 1'b1, res_overflow, res_error, busy, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tok_ready_after_rst", 32'(tok_ready), 32'd1);

        // 5 3 + 2 * end = 16
        op_log.delete();
        send_tok(TOK_OPND, 8'd5); send_tok(TOK_OPND, 8'd3); send_tok(TOK_ADD, '0);
        send_tok(TOK_OPND, 8'd2); send_tok(TOK_MUL, '0); send_tok(TOK_END, '0);
        expect_result(8'd16, 1'b0, 1'b0, 2);
        wait_result(0);
        check("ops_count", 32'(op_log.size()), 32'd6);
        if (op_log.size() == 6)
            for (int i = 0; i < 6; i++) check("ops_seq", 32'(op_log[i]), 32'(exp_ops[i]));

        // 40 30 * end: product 1200 wraps to 176 with overflow
        send_tok(TOK_OPND, 8'd40); send_tok(TOK_OPND, 8'd30); send_tok(TOK_MUL, '0);
        send_tok(TOK_END, '0);
        expect_result(8'd176, 1'b1, 1'b0, 2);
        wait_result(0);

        // 200 100 + end: add overflow, 300 wraps to 44
        send_tok(TOK_OPND, 8'd200); send_tok(TOK_OPND, 8'd100); send_tok(TOK_ADD, '0);
        send_tok(TOK_END, '0);
        expect_result(8'd44, 1'b1, 1'b0, 2);
        wait_result(0);

        // 5 + end: add suppressed, error, result 5; result held 4 cycles
        op_log.delete();
        send_tok(TOK_OPND, 8'd5); send_tok(TOK_ADD, '0); send_tok(TOK_END, '0);
        expect_result(8'd5, 1'b0, 1'b1, 2);
        wait_result(4);
        check("underflow_ops", 32'(op_log.size()), 32'd2);
        check("underflow_pops", 32'(count_op(OP_POP)), 32'd1);

        // DEPTH+1 operands: last push dropped, DEPTH pops, top is operand DEPTH
        op_log.delete();
        for (int i = 1; i <= DEPTH + 1; i++) send_tok(TOK_OPND, 8'(i));
        send_tok(TOK_END, '0);
        expect_result(8'(DEPTH), 1'b0, 1'b1, DEPTH + 1);
        wait_result(0);
        check("overflow_pushes", 32'(count_op(OP_PUSH)), 32'(DEPTH));
        check("overflow_pops", 32'(count_op(OP_POP)), 32'(DEPTH));

        // Bare end: empty stack, result 0, error, no pops
        op_log.delete();
        send_tok(TOK_END, '0);
        expect_result(8'd0, 1'b0, 1'b1, 1);
        wait_result(0);
        check("empty_ops", 32'(op_log.size()), 32'd0);

        // Reset in the middle of flushing a 3-deep stack
        op_log.delete();
        send_tok(TOK_OPND, 8'd1); send_tok(TOK_OPND, 8'd2); send_tok(TOK_OPND, 8'd3);
        send_tok(TOK_END, '0);
        @(negedge clk);
        tok_valid = 1'b0;
        check("flush_pop_on_bus", 32'(alu_opcode), 32'(OP_POP));
        rst = 1'b1;
        #1;
        check("rst_flush_opcode", 32'(alu_opcode), 32'd0);
        check("rst_flush_valid", 32'(res_valid), 32'd0);
        check("rst_flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_flush_no_pops", 32'(count_op(OP_POP)), 32'd0);
        @(posedge clk);
        #1;
        check("rst_flush_tok_ready", 32'(tok_ready), 32'd1);
        check("rst_flush_opcode_after", 32'(alu_opcode), 32'd0);

        // Normal expression after the reset
        send_tok(TOK_OPND, 8'd7); send_tok(TOK_OPND, 8'd8); send_tok(TOK_ADD, '0);
        send_tok(TOK_END, '0);
        expect_result(8'd15, 1'b0, 1'b0, 2);
        wait_result(0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
